// File: rtl/product_accumulator.sv
// Burst accumulator: sums COUNT unsigned products, then holds the result until taken.
// Optional macro PRODUCT_ACCUMULATOR_SATURATE_EN: saturate acc to all-ones on overflow instead of wrapping.
module product_accumulator #(
  parameter int SIZE      = 8,
  parameter int ACC_WIDTH = 17,
  parameter int COUNT     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*SIZE-1:0]    product,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 acc_overflow,
  output logic [7:0]           count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t               state;
  logic                 accept;
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [7:0]           count_next;
  logic                 last;

  assign in_ready = (state != HOLD) && !clear;
  assign accept   = in_valid && in_ready;

  always_comb begin
    sum        = {1'b0, acc} + {{(ACC_WIDTH + 1 - 2*SIZE){1'b0}}, product};
    count_next = count + 8'd1;
    last       = (count_next == 8'(COUNT));
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    // Once saturated, stay pinned at all-ones for the rest of the burst.
    acc_next   = (sum[ACC_WIDTH] || acc_overflow) ? '1 : sum[ACC_WIDTH-1:0];
`else
    acc_next   = sum[ACC_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state        <= IDLE;
      acc          <= '0;
      count        <= '0;
      acc_overflow <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc          <= ACC_WIDTH'(product);
            count        <= 8'd1;
            acc_overflow <= 1'b0;
            if (COUNT == 1) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc          <= acc_next;
            count        <= count_next;
            acc_overflow <= acc_overflow | sum[ACC_WIDTH];
            if (last) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator (SIZE=8, ACC_WIDTH=17, COUNT=4) with a sum-based reference model.
module tb_product_accumulator;

  localparam int    SIZE  = 8;
  localparam int    ACC_W = 17;
  localparam int    CNT   = 4;
  localparam longint MOD  = 64'd1 << ACC_W;

  typedef struct {
    longint acc;
    int     cnt;
    bit     ovf;
  } res_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2*SIZE-1:0] product = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] acc;
  logic             acc_overflow;
  logic [7:0]       count;

  int n_cmp  = 0;
  int n_fail = 0;

  res_t   sb[$];
  int     m_n    = 0;
  longint m_sum  = 0;
  bit     m_full = 1'b0;

  product_accumulator #(
    .SIZE      (SIZE),
    .ACC_WIDTH (ACC_W),
    .COUNT     (CNT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .product      (product),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .acc          (acc),
    .acc_overflow (acc_overflow),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ovf();
    return (m_n != 0) && (m_sum >= MOD);
  endfunction

  function automatic longint exp_acc();
    if (m_n == 0) return 0;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    return exp_ovf() ? MOD - 1 : m_sum;
`else
    return m_sum % MOD;
`endif
  endfunction

  // One clock cycle: drive inputs, check in_ready mid-cycle, update the model, check registers after the edge.
  task automatic cycle(input bit r, input bit c, input bit v, input bit o, input logic [2*SIZE-1:0] p);
    res_t res;
    rst = r; clear = c; in_valid = v; out_ready = o; product = p;
    @(negedge clk);
    chk("in_ready", longint'(in_ready), longint'(!m_full && !c));
    if (r || c) begin
      if (m_full) void'(sb.pop_back());
      m_n = 0; m_sum = 0; m_full = 1'b0;
    end else if (m_full) begin
      if (o) m_full = 1'b0;
    end else if (v) begin
      if (m_n == 0 || m_n == CNT) begin
        m_n = 1; m_sum = longint'(p);
      end else begin
        m_n++; m_sum += longint'(p);
      end
      if (m_n == CNT) begin
        m_full  = 1'b1;
        res.acc = exp_acc();
        res.cnt = CNT;
        res.ovf = exp_ovf();
        sb.push_back(res);
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", longint'(out_valid), longint'(m_full));
    chk("count", longint'(count), longint'(m_n));
    chk("acc", longint'(acc), exp_acc());
    chk("acc_overflow", longint'(acc_overflow), longint'(exp_ovf()));
  endtask

  initial begin
    fork
      begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
      end
      forever begin
        @(negedge clk);
        if (!rst && !clear && out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("sb_unexpected_output", 1, 0);
          end else begin
            res_t e;
            e = sb.pop_front();
            chk("sb_acc", longint'(acc), e.acc);
            chk("sb_count", longint'(count), longint'(e.cnt));
            chk("sb_overflow", longint'(acc_overflow), longint'(e.ovf));
          end
        end
      end
    join_none

    repeat (3) cycle(1, 0, 0, 1, '0);
    chk("reset_acc", longint'(acc), 0);
    chk("reset_out_valid", longint'(out_valid), 0);

    // basic burst
    cycle(0, 0, 1, 1, 16'd1);
    cycle(0, 0, 1, 1, 16'd2);
    cycle(0, 0, 1, 1, 16'd3);
    cycle(0, 0, 1, 1, 16'd4);
    chk("basic_acc", longint'(acc), 10);
    chk("basic_count", longint'(count), 4);
    chk("basic_valid", longint'(out_valid), 1);
    cycle(0, 0, 0, 1, '0);
    chk("basic_idle_valid", longint'(out_valid), 0);
    chk("basic_acc_kept", longint'(acc), 10);

    // overflow burst, then backpressure with in_valid held high
    repeat (4) cycle(0, 0, 1, 0, 16'hFE01);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    chk("ovf_acc", longint'(acc), 'h1FFFF);
`else
    chk("ovf_acc", longint'(acc), 129028);
`endif
    chk("ovf_flag", longint'(acc_overflow), 1);
    repeat (5) cycle(0, 0, 1, 0, 16'd99);
    chk("bp_count", longint'(count), 4);
    cycle(0, 0, 0, 1, '0);
    chk("bp_release_valid", longint'(out_valid), 0);
    cycle(0, 0, 0, 1, '0);

    // clear mid-burst with a product offered in the same cycle
    cycle(0, 0, 1, 1, 16'd7);
    cycle(0, 0, 1, 1, 16'd8);
    cycle(0, 1, 1, 1, 16'd9);
    chk("clear_acc", longint'(acc), 0);
    chk("clear_count", longint'(count), 0);
    cycle(0, 0, 0, 1, '0);

    // reset in ACCUM, then reset in HOLD
    cycle(0, 0, 1, 1, 16'd3);
    cycle(0, 0, 1, 1, 16'd4);
    cycle(1, 0, 1, 1, 16'd5);
    chk("rst_accum_count", longint'(count), 0);
    repeat (4) cycle(0, 0, 1, 0, 16'd11);
    cycle(1, 0, 1, 1, 16'd5);
    chk("rst_hold_valid", longint'(out_valid), 0);
    repeat (4) cycle(0, 0, 1, 1, 16'd5);
    chk("rst_new_burst_acc", longint'(acc), 20);
    cycle(0, 0, 0, 1, '0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [2*SIZE-1:0] p;
      p = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6), p);
    end

    repeat (4) cycle(0, 0, 0, 1, '0);
    chk("sb_drained", longint'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
